// File: rtl/bist_resp_analyzer.sv
// BIST response analyzer: compares expected vs. read data over a session (IDLE/ACTIVE/DONE)
// and records the relation, sticky fail, saturating fail count and first failure. Mask: BIST_RESP_MASK_EN.
module bist_resp_analyzer #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cmp_vld,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_t,
    input  logic [DW-1:0] ramout,
    input  logic          end_test,
`ifdef BIST_RESP_MASK_EN
    input  logic [DW-1:0] mask,
`endif
    output logic          gt,
    output logic          eq,
    output logic          lt,
    output logic          res_vld,
    output logic          fail,
    output logic [CW-1:0] fail_cnt,
    output logic [AW-1:0] ff_addr,
    output logic [DW-1:0] ff_xor,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        r_state;
    logic          r_gt, r_eq, r_lt, r_res_vld, r_fail, r_busy, r_done;
    logic [CW-1:0] r_fail_cnt;
    logic [AW-1:0] r_ff_addr;
    logic [DW-1:0] r_ff_xor;

    logic [DW-1:0] w_exp, w_got;
    logic          w_proc, w_mis;

`ifdef BIST_RESP_MASK_EN
    assign w_exp = data_t & ~mask;
    assign w_got = ramout & ~mask;
`else
    assign w_exp = data_t;
    assign w_got = ramout;
`endif

    // A start edge opens a fresh session, so any compare presented with it is dropped.
    assign w_proc = (r_state == ACTIVE) && cmp_vld && !start;
    assign w_mis  = (w_exp != w_got);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gt       <= 1'b0;
            r_eq       <= 1'b0;
            r_lt       <= 1'b0;
            r_res_vld  <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_cnt <= '0;
            r_ff_addr  <= '0;
            r_ff_xor   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_res_vld <= 1'b0;
            if (start) begin
                r_state    <= ACTIVE;
                r_gt       <= 1'b0;
                r_eq       <= 1'b0;
                r_lt       <= 1'b0;
                r_fail     <= 1'b0;
                r_fail_cnt <= '0;
                r_ff_addr  <= '0;
                r_ff_xor   <= '0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
            end else begin
                if (w_proc) begin
                    r_gt      <= (w_exp > w_got);
                    r_eq      <= !w_mis;
                    r_lt      <= (w_exp < w_got);
                    r_res_vld <= 1'b1;
                    if (w_mis) begin
                        r_fail <= 1'b1;
                        if (r_fail_cnt != CNT_MAX) begin
                            r_fail_cnt <= r_fail_cnt + 1'b1;
                        end
                        // First failure of the session is the one worth diagnosing.
                        if (!r_fail) begin
                            r_ff_addr <= addr;
                            r_ff_xor  <= w_exp ^ w_got;
                        end
                    end
                end
                if ((r_state == ACTIVE) && end_test) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign gt       = r_gt;
    assign eq       = r_eq;
    assign lt       = r_lt;
    assign res_vld  = r_res_vld;
    assign fail     = r_fail;
    assign fail_cnt = r_fail_cnt;
    assign ff_addr  = r_ff_addr;
    assign ff_xor   = r_ff_xor;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_bist_resp_analyzer.sv
// Scoreboard bench for bist_resp_analyzer: directed cases plus randomized sessions
// checked against a session-level reference model.
module tb_bist_resp_analyzer;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int CW = 2;
    localparam int MAXC = (1 << CW) - 1;
    localparam int M_IDLE = 0, M_ACT = 1, M_DONE = 2;

    logic          clk, rst, start, cmp_vld, end_test;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_t, ramout, mask_v;
    logic          gt, eq, lt, res_vld, fail, busy, done;
    logic [CW-1:0] fail_cnt;
    logic [AW-1:0] ff_addr;
    logic [DW-1:0] ff_xor;

    bist_resp_analyzer #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .cmp_vld(cmp_vld), .addr(addr),
        .data_t(data_t), .ramout(ramout), .end_test(end_test),
`ifdef BIST_RESP_MASK_EN
        .mask(mask_v),
`endif
        .gt(gt), .eq(eq), .lt(lt), .res_vld(res_vld), .fail(fail),
        .fail_cnt(fail_cnt), .ff_addr(ff_addr), .ff_xor(ff_xor),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic          gt, eq, lt, fail;
        logic [CW-1:0] cnt;
        logic [AW-1:0] fa;
        logic [DW-1:0] fx;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: session-level bookkeeping
    int            m_state;
    int            m_fails;
    bit            m_have_first;
    logic [AW-1:0] m_ff_addr;
    logic [DW-1:0] m_ff_xor;
    logic          m_gt, m_eq, m_lt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_cnt();
        return (m_fails > MAXC) ? MAXC : m_fails;
    endfunction

    task automatic model_clear();
        m_fails = 0; m_have_first = 0; m_ff_addr = '0; m_ff_xor = '0;
        m_gt = 0; m_eq = 0; m_lt = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_busy"}, busy, m_state == M_ACT);
        check({tag, "_done"}, done, m_state == M_DONE);
        check({tag, "_fail"}, fail, m_fails > 0);
        check({tag, "_cnt"}, fail_cnt, sat_cnt());
        check({tag, "_ffaddr"}, ff_addr, m_ff_addr);
        check({tag, "_ffxor"}, ff_xor, m_ff_xor);
        check({tag, "_rel"}, {gt, eq, lt}, {m_gt, m_eq, m_lt});
    endtask

    task automatic cycle(input logic st, input logic cv, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] r,
                         input logic et, input logic [DW-1:0] mk);
        exp_t e;
        logic [DW-1:0] x, y;
        @(negedge clk);
        start = st; cmp_vld = cv; addr = a; data_t = d; ramout = r; end_test = et; mask_v = mk;
        if (st) begin
            m_state = M_ACT;
            model_clear();
        end else if (m_state == M_ACT) begin
            if (cv) begin
                x = d; y = r;
`ifdef BIST_RESP_MASK_EN
                x = d & ~mk; y = r & ~mk;
`endif
                m_gt = (x > y); m_eq = (x == y); m_lt = (x < y);
                if (!m_eq) begin
                    m_fails++;
                    if (!m_have_first) begin
                        m_have_first = 1; m_ff_addr = a; m_ff_xor = x ^ y;
                    end
                end
                e.gt = m_gt; e.eq = m_eq; e.lt = m_lt; e.fail = (m_fails > 0);
                e.cnt = CW'(sat_cnt()); e.fa = m_ff_addr; e.fx = m_ff_xor;
                sb_q.push_back(e);
            end
            if (et) m_state = M_DONE;
        end
        @(posedge clk);
        #1;
        start = 0; cmp_vld = 0; end_test = 0;
        check_state("cyc");
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("rst_fail", fail, 0);
        check("rst_cnt", fail_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rel", {gt, eq, lt, res_vld}, 0);
        check("rst_ff", {ff_addr, ff_xor}, 0);
        m_state = M_IDLE;
        model_clear();
        #1 rst = 0;
    endtask

    // Monitor: every res_vld pulse consumes one expected result
    always @(negedge clk) begin
        if (res_vld) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected res_vld=1 expected no result at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_rel", {gt, eq, lt}, {e.gt, e.eq, e.lt});
                check("sb_fail", fail, e.fail);
                check("sb_cnt", fail_cnt, e.cnt);
                check("sb_ffaddr", ff_addr, e.fa);
                check("sb_ffxor", ff_xor, e.fx);
            end
        end
    end

    initial begin
        int n;
        logic [DW-1:0] d, r;
        rst = 1; start = 0; cmp_vld = 0; end_test = 0; addr = '0;
        data_t = '0; ramout = '0; mask_v = '0;
        m_state = M_IDLE;
        model_clear();
        #1;
        check("reset_outs", {gt, eq, lt, res_vld, fail, busy, done}, 0);
        check("reset_data", {fail_cnt, ff_addr, ff_xor}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // compare in IDLE is ignored
        cycle(0, 1, 8'h01, 8'h11, 8'h22, 0, 0);
        check("idle_res_vld", res_vld, 0);

        // eq case
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 8'h00, 8'h5A, 8'h5A, 0, 0);
        check("r037_eq", eq, 1);
        check("r037_res_vld", res_vld, 1);
        check("r037_fail", {fail, fail_cnt}, 0);

        // gt then lt, first-fail capture
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 8'h03, 8'h80, 8'h7F, 0, 0);
        check("r038_gt", gt, 1);
        cycle(0, 1, 8'h09, 8'h10, 8'h20, 0, 0);
        check("r038_lt", lt, 1);
        check("r038_cnt", fail_cnt, 2);
        check("r038_ffaddr", ff_addr, 8'h03);
        check("r038_ffxor", ff_xor, 8'hFF);

        // saturation
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(i), 8'(i), 8'(i + 1), 0, 0);
        check("r039_sat", fail_cnt, 3);

        // compare on end_test edge, then start clears
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 8'h04, 8'h33, 8'h33, 0, 0);
        cycle(0, 1, 8'h05, 8'h31, 8'h33, 1, 0);
        check("r040_done", done, 1);
        check("r040_cnt", fail_cnt, 1);
        cycle(0, 1, 8'h06, 8'h00, 8'h01, 0, 0);
        check("r040_hold", {fail_cnt, ff_addr}, {2'd1, 8'h05});
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("r040_clear", {fail, fail_cnt, ff_addr, ff_xor, gt, eq, lt, done}, 0);

        // start + end_test together, compare on start edge ignored
        cycle(1, 1, 8'h07, 8'h01, 8'h02, 1, 0);
        check("start_wins_busy", busy, 1);
        check("start_cmp_ignored", res_vld, 0);

        // async reset mid-session
        cycle(0, 1, 8'h08, 8'hF0, 8'h0F, 0, 0);
        reset_mid();
        cycle(0, 0, 0, 0, 0, 0, 0);

`ifdef BIST_RESP_MASK_EN
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 8'h0A, 8'hA5, 8'hA3, 0, 8'h0F);
        check("r042_eq", {eq, fail}, 2'b10);
        cycle(0, 1, 8'h0B, 8'hA5, 8'hA3, 0, 8'h00);
        check("r042_gt", gt, 1);
        check("r042_ffxor", ff_xor, 8'h06);
`endif

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            cycle(1, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                if ((s % 7 == 3) && (i == n / 2)) reset_mid();
                d = 8'($urandom);
                case ($urandom % 3)
                    0: r = d;
                    1: r = d ^ (8'b1 << ($urandom % 8));
                    default: r = 8'($urandom);
                endcase
                cycle((s % 5 == 2) && (i == n / 2), ($urandom % 4) != 0, 8'($urandom), d, r,
                      i == n - 1, ($urandom % 2) ? 8'($urandom) : 8'h00);
            end
            for (int k = 0; k < 2; k++)
                cycle(0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bist_resp_analyzer.md
BIST_RESP_ANALYZER -- requirements
Module: bist_resp_analyzer

Interface
REQ-001 SHALL provide parameter DW, default 8, compared data width in bits.
REQ-002 SHALL provide parameter AW, default 8, memory address width in bits.
REQ-003 SHALL provide parameter CW, default 8, fail-counter width in bits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a test session.
REQ-007 cmp_vld  input  1  data_t/ramout/addr valid this cycle.
REQ-008 addr  input  AW  address of the word being compared.
REQ-009 data_t  input  DW  expected data.
REQ-010 ramout  input  DW  data read from memory.
REQ-011 end_test  input  1  one-cycle pulse; closes the session.
REQ-012 mask  input  DW  per-bit compare mask, 1 = ignore bit; present only when BIST_RESP_MASK_EN is defined.
REQ-013 gt, eq, lt  output  1 each  registered magnitude relation of the last valid compare.
REQ-014 res_vld  output  1  one-cycle pulse when gt/eq/lt update.
REQ-015 fail  output  1  sticky: at least one mismatch in the session.
REQ-016 fail_cnt  output  CW  number of mismatching compares, saturating.
REQ-017 ff_addr  output  AW  address of the first mismatch.
REQ-018 ff_xor  output  DW  data_t XOR ramout (masked) of the first mismatch.
REQ-019 busy  output  1  high in state ACTIVE.
REQ-020 done  output  1  high in state DONE.

Function
REQ-021 SHALL implement FSM states IDLE, ACTIVE, DONE; reset state IDLE.
REQ-022 IDLE->ACTIVE on start; ACTIVE->DONE on end_test; DONE->ACTIVE on start; DONE holds otherwise.
REQ-023 start in any state SHALL clear fail, fail_cnt, ff_addr, ff_xor, gt, eq, lt on the same edge and enter ACTIVE.
REQ-024 start and end_test in the same cycle: start wins, end_test ignored.
REQ-025 cmp_vld SHALL be ignored outside ACTIVE; on the start edge it SHALL also be ignored.
REQ-026 Pipeline latency SHALL be one cycle: inputs sampled at edge N, gt/eq/lt/res_vld/fail/fail_cnt/ff_* valid after edge N.
REQ-027 Exactly one of gt/eq/lt SHALL be high after the first valid compare; all low before it.
REQ-028 Compare SHALL be unsigned on DW bits (after masking where enabled).
REQ-029 Mismatch = not eq; each mismatch SHALL increment fail_cnt, holding at 2^CW-1.
REQ-030 ff_addr/ff_xor SHALL load only on the first mismatch of a session, then hold.
REQ-031 A cmp_vld sampled on the end_test edge SHALL still be processed.
REQ-032 All outputs SHALL hold their values in DONE until the next start.

Reset
REQ-033 rst SHALL immediately force IDLE and zero every output, independent of clk.
REQ-034 rst mid-session SHALL discard all results; no partial result survives deassertion.

Configuration
REQ-035 With BIST_RESP_MASK_EN defined, data_t and ramout SHALL each be ANDed with ~mask before compare and XOR capture; masked bits never cause a mismatch.
REQ-036 Without BIST_RESP_MASK_EN, the mask port SHALL not exist and all DW bits SHALL be compared.

Verification
REQ-037 DW=8: start; cmp_vld with data_t=0x5A, ramout=0x5A -> next cycle eq=1, res_vld=1, fail=0, fail_cnt=0.
REQ-038 Compares (addr 0x03, 0x80/0x7F) then (addr 0x09, 0x10/0x20) -> first gt=1, second lt=1; fail=1, fail_cnt=2, ff_addr=0x03, ff_xor=0xFF.
REQ-039 CW=2: five mismatching compares -> fail_cnt holds 3.
REQ-040 end_test with cmp_vld mismatch on the same edge -> done=1, fail_cnt includes it; start then clears all outputs.
REQ-041 rst asserted mid-session after a mismatch -> fail=0, fail_cnt=0, busy=0, done=0 without a clock edge.
REQ-042 BIST_RESP_MASK_EN: mask=0x0F, data_t=0xA5, ramout=0xA3 -> eq=1, fail=0; mask=0x00 same data -> gt=1, ff_xor=0x06.
